// File: rtl/reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg_wr_arbiter
//  Purpose  : Two-port write arbiter and enable sequencer for a bank of
//             register instances. Picks one requester per cycle with
//             alternating priority under contention, then drives a
//             registered one-hot write enable and write data one cycle later.
//  Ports    : clk, reset           - clock, async active-high reset
//             req{0,1}_valid/addr/data/ready - write request handshakes
//             stall                - blocks all grants this cycle
//             cnt_clr              - synchronous clear of conflict_cnt
//             wr_en, wr_data       - registered enable/data to register bank
//             prio                 - port currently holding priority
//             conflict_cnt         - saturating count of contended cycles
//  Revision : 1.0 - initial release
// ============================================================================
module reg_wr_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [AW-1:0]    req0_addr,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [AW-1:0]    req1_addr,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    input  logic             stall,
    input  logic             cnt_clr,
    output logic [NREG-1:0]  wr_en,
    output logic [WIDTH-1:0] wr_data,
    output logic             prio,
    output logic [7:0]       conflict_cnt
);

    localparam logic [7:0] C_CNT_MAX = 8'hFF;

    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_xfer;
    logic             w_contend;
    logic [AW-1:0]    w_addr;
    logic [WIDTH-1:0] w_data;
    logic [NREG-1:0]  w_dec;

    // Grants are withheld while reset is high so nothing is accepted that
    // would be lost to the clearing write stage.
    always_comb begin
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_contend = 1'b0;
        if (!reset && !stall) begin
            w_contend = req0_valid && req1_valid;
            w_gnt0    = req0_valid && (!req1_valid || (prio == 1'b0));
            w_gnt1    = req1_valid && (!req0_valid || (prio == 1'b1));
        end
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign w_xfer     = w_gnt0 || w_gnt1;
    assign w_addr     = w_gnt0 ? req0_addr : req1_addr;
    assign w_data     = w_gnt0 ? req0_data : req1_data;

    // One-hot decode; addresses at or above NREG match no bit, so the
    // handshake completes but the write is silently dropped.
    always_comb begin
        w_dec = '0;
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = w_xfer && (w_addr == AW'(i));
        end
    end

    // wr_en/wr_data are driven straight from flops so the bank's gated
    // clock (clk AND en) never sees a combinational glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en        <= '0;
            wr_data      <= '0;
            prio         <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            wr_en <= w_dec;
            if (w_xfer) begin
                wr_data <= w_data;
            end
            // Under contention the winner is the port equal to prio, so the
            // loser (which gains priority) is always the inverse.
            if (w_contend) begin
                prio <= ~prio;
            end
            if (cnt_clr) begin
                conflict_cnt <= '0;
            end else if (w_contend && (conflict_cnt != C_CNT_MAX)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_wr_arbiter
//  Purpose  : Directed self-checking bench for reg_wr_arbiter (NREG=6 so that
//             out-of-range addresses exist with AW=3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int NREG  = 6;
    localparam int AW    = 3;

    logic             clk;
    logic             reset;
    logic             req0_valid;
    logic [AW-1:0]    req0_addr;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [AW-1:0]    req1_addr;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             stall;
    logic             cnt_clr;
    logic [NREG-1:0]  wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             prio;
    logic [7:0]       conflict_cnt;

    int nvec  = 0;
    int nfail = 0;

    logic [WIDTH-1:0] bank [0:NREG-1];

    reg_wr_arbiter #(.WIDTH(WIDTH), .NREG(NREG), .AW(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (req0_valid),
        .req0_addr    (req0_addr),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_addr    (req1_addr),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .stall        (stall),
        .cnt_clr      (cnt_clr),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .prio         (prio),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the register bank fed by the arbiter.
    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (wr_en[i]) bank[i] <= wr_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) bank[i] = '0;
        reset = 1'b1; stall = 1'b0; cnt_clr = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;

        // Reset state; a valid request during reset must not be accepted.
        #2;
        req0_valid = 1'b1;
        #1;
        chk("rst_ready0", 32'(req0_ready), 32'd0);
        tick();
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_prio", 32'(prio), 32'd0);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);
        req0_valid = 1'b0;
        reset = 1'b0;
        tick();

        // Single write: addr 3, data 0xA5.
        req0_valid = 1'b1; req0_addr = 3'd3; req0_data = 8'hA5;
        #1;
        chk("single_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("single_wr_en", 32'(wr_en), 32'b001000);
        chk("single_wr_data", 32'(wr_data), 32'hA5);
        tick();
        chk("single_wr_en_off", 32'(wr_en), 32'd0);
        chk("single_data_hold", 32'(wr_data), 32'hA5);
        chk("single_bank3", 32'(bank[3]), 32'hA5);

        // Contention alternation: p0 (1,0x11) vs p1 (2,0x22) for 4 cycles.
        req0_valid = 1'b1; req0_addr = 3'd1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_prio_before", 32'(prio), 32'(i % 2));
            chk("alt_ready0", 32'(req0_ready), 32'((i % 2) == 0));
            chk("alt_ready1", 32'(req1_ready), 32'((i % 2) == 1));
            tick();
            chk("alt_wr_en", 32'(wr_en), ((i % 2) == 0) ? 32'b000010 : 32'b000100);
            chk("alt_wr_data", 32'(wr_data), ((i % 2) == 0) ? 32'h11 : 32'h22);
            chk("alt_prio_after", 32'(prio), 32'((i + 1) % 2));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("alt_cnt", 32'(conflict_cnt), 32'd4);
        tick();
        chk("alt_idle_wr_en", 32'(wr_en), 32'd0);

        // Same-address race: both to addr 5, prio 0 so p0 first, p1 wins.
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 8'h01;
        req1_valid = 1'b1; req1_addr = 3'd5; req1_data = 8'h02;
        #1;
        chk("race_ready0", 32'(req0_ready), 32'd1);
        chk("race_ready1_block", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("race_wr_en1", 32'(wr_en), 32'b100000);
        chk("race_wr_data1", 32'(wr_data), 32'h01);
        #1;
        chk("race_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("race_wr_en2", 32'(wr_en), 32'b100000);
        chk("race_wr_data2", 32'(wr_data), 32'h02);
        chk("race_prio", 32'(prio), 32'd1);
        chk("race_cnt", 32'(conflict_cnt), 32'd5);
        tick();
        chk("race_wr_en_off", 32'(wr_en), 32'd0);
        chk("race_bank5", 32'(bank[5]), 32'h02);

        // Stall blocks p1; then out-of-range address 7 is accepted but dropped.
        stall = 1'b1;
        req1_valid = 1'b1; req1_addr = 3'd2; req1_data = 8'h33;
        #1;
        chk("stall_ready0", 32'(req0_ready), 32'd0);
        chk("stall_ready1", 32'(req1_ready), 32'd0);
        tick();
        chk("stall_wr_en", 32'(wr_en), 32'd0);
        chk("stall_data_hold", 32'(wr_data), 32'h02);
        stall = 1'b0;
        req1_addr = 3'd7; req1_data = 8'h77;
        #1;
        chk("oor_ready1", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        chk("oor_wr_en", 32'(wr_en), 32'd0);
        chk("oor_wr_data", 32'(wr_data), 32'h77);
        chk("oor_prio", 32'(prio), 32'd1);
        tick();

        // Counter saturation and clear under continuous contention.
        req0_valid = 1'b1; req0_addr = 3'd0; req0_data = 8'h5A;
        req1_valid = 1'b1; req1_addr = 3'd4; req1_data = 8'hC3;
        for (int i = 0; i < 300; i++) tick();
        chk("sat_cnt", 32'(conflict_cnt), 32'd255);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", 32'(conflict_cnt), 32'd0);
        tick();
        chk("clr_cnt_resume", 32'(conflict_cnt), 32'd1);

        // Async reset between edges while a write is in flight.
        chk("arst_pre_wr_en", 32'(wr_en != '0), 32'd1);
        chk("arst_pre_prio", 32'(prio), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_prio", 32'(prio), 32'd0);
        chk("arst_cnt", 32'(conflict_cnt), 32'd0);
        chk("arst_ready0", 32'(req0_ready), 32'd0);
        chk("arst_ready1", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
